// File: rtl/async_rx_bridge.sv
// Clocked receiver for a 4-phase bundled-data channel: synchronises lreq, captures ldata into a small FIFO, streams it out.
// Optional macro ASYNC_RX_SYNC3_EN selects a 3-flop request synchroniser (default is 2 flops).
module async_rx_bridge #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lreq,
  output logic             lack,
  input  logic [WIDTH-1:0] ldata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef ASYNC_RX_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  typedef enum logic [1:0] {
    RST_DRAIN    = 2'd0,
    WAIT_REQ     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SYNC_N-1:0]  sync_p0;
  logic               req_s;
  logic               push, pop, full;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];

  // Stage p0: request synchroniser; flops reset high so a request held across reset is drained first
  always_ff @(posedge clk) begin
    if (rst) sync_p0 <= '1;
    else     sync_p0 <= {sync_p0[SYNC_N-2:0], lreq};
  end

  assign req_s = sync_p0[SYNC_N-1];
  assign full  = (count == FULL_CNT);
  assign pop   = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      RST_DRAIN:    if (!req_s) state_nxt = WAIT_REQ;
      WAIT_REQ: begin
        // full is taken before this cycle's pop, so a full FIFO never passes a token through
        if (req_s && !full) begin
          push      = 1'b1;
          state_nxt = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: if (!req_s) state_nxt = WAIT_REQ;
      default:      state_nxt = RST_DRAIN;
    endcase
  end

  // Stage p1: handshake state and registered acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_DRAIN;
      lack  <= 1'b0;
    end else begin
      state <= state_nxt;
      lack  <= (state_nxt == WAIT_RELEASE);
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      out_valid <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // ldata is captured unsynchronised: bundled timing guarantees it has been stable for the synchroniser delay
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= ldata;
    end
  end

  assign out_data = mem[rd_ptr];

  a_no_push_full:  assert property (@(posedge clk) disable iff (rst) push |-> !full);
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) pop |-> (count != '0));
  a_no_lack_drain: assert property (@(posedge clk) disable iff (rst) (state == RST_DRAIN) |-> !lack);

endmodule

// File: tb/tb_async_rx_bridge.sv
// Randomised bench for async_rx_bridge: a 4-phase upstream driver plus a token-queue reference model.
module tb_async_rx_bridge;

  localparam int WIDTH = 10;
  localparam int DEPTH = 2;
`ifdef ASYNC_RX_SYNC3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             lreq;
  logic             lack;
  logic [WIDTH-1:0] ldata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ready_cmd;
  logic             rand_ready = 1'b0;
  logic             rand_en = 1'b0;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int max_occ  = 0;
  logic [WIDTH-1:0] exp_q[$];
  int occ_prev = 0;
  logic lack_prev = 1'b0;

  assign out_ready = rand_en ? rand_ready : ready_cmd;

  async_rx_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .lreq(lreq), .lack(lack), .ldata(ldata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2 rand_ready = 1'($urandom_range(0, 1));
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a token enters the queue when its ack is seen, leaves on each accepted handshake
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      occ_prev = 0;
    end else begin
      if (lack && !lack_prev) begin
        check_eq("capture_only_when_not_full", 32'(occ_prev < DEPTH), 32'd1);
        exp_q.push_back(ldata);
      end
      check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) check_eq("out_data", 32'(out_data), 32'(exp_q[0]));
      if (exp_q.size() > max_occ) max_occ = exp_q.size();
      occ_prev = exp_q.size();
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
    lack_prev = lack;
  end

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_lack(input logic v, input string tag);
    int n = 0;
    while (lack !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(lack), 32'(v));
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    drive_slot();
    ldata = d;
    lreq  = 1'b1;
    wait_lack(1'b1, "ack_rise");
    drive_slot();
    lreq = 1'b0;
    wait_lack(1'b0, "ack_fall");
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pops_before;
    rst = 1'b1; lreq = 1'b0; ldata = '0; ready_cmd = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_lack", 32'(lack), 32'd0);
    check_eq("reset_valid", 32'(out_valid), 32'd0);
    check_eq("reset_data", 32'(out_data), 32'd0);
    repeat (5) @(negedge clk);

    // Single token with exact handshake latency
    ready_cmd = 1'b1;
    drive_slot();
    ldata = 10'h155;
    lreq  = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!lack && n < 20);
    check_eq("rise_latency", 32'(n), 32'(LAT));
    check_eq("single_valid", 32'(out_valid), 32'd1);
    check_eq("single_data", 32'(out_data), 32'h155);
    #1 lreq = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (lack && n < 20);
    check_eq("fall_latency", 32'(n), 32'(LAT));
    drain("single_drain");

    // Backpressure: third token held off while the FIFO is full
    ready_cmd = 1'b0;
    send(10'd1);
    send(10'd2);
    drive_slot();
    ldata = 10'd3;
    lreq  = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("bp_lack_held", 32'(lack), 32'd0);
    check_eq("bp_head", 32'(out_data), 32'd1);
    ready_cmd = 1'b1;
    wait_lack(1'b1, "bp_third_ack");
    drive_slot();
    lreq = 1'b0;
    wait_lack(1'b0, "bp_third_release");
    drain("bp_drain");

    // Simultaneous push and pop with one token held
    ready_cmd = 1'b0;
    send(10'h2AA);
    drive_slot();
    ldata = 10'h0F0;
    lreq  = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #2 ready_cmd = 1'b1;
    @(posedge clk);
    #2 ready_cmd = 1'b0;
    @(negedge clk);
    check_eq("simul_lack", 32'(lack), 32'd1);
    check_eq("simul_valid", 32'(out_valid), 32'd1);
    check_eq("simul_head", 32'(out_data), 32'h0F0);
    drive_slot();
    lreq = 1'b0;
    wait_lack(1'b0, "simul_release");
    ready_cmd = 1'b1;
    drain("simul_drain");

    // Pointer wrap with a free-flowing sink
    max_occ = 0;
    pops_before = pops;
    for (int i = 0; i < 9; i++) send(WIDTH'(i));
    drain("wrap_drain");
    check_eq("wrap_max_occ", 32'(max_occ <= 1), 32'd1);
    check_eq("wrap_count", 32'(pops - pops_before), 32'd9);

    // Randomised tokens, gaps and sink readiness
    rand_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(WIDTH'($urandom));
    end
    rand_en = 1'b0;
    ready_cmd = 1'b1;
    drain("rand_drain");

    // Reset in the middle of a handshake with lreq held high
    ready_cmd = 1'b0;
    drive_slot();
    ldata = 10'h111;
    lreq  = 1'b1;
    wait_lack(1'b1, "rstmid_ack");
    drive_slot();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("rstmid_lack", 32'(lack), 32'd0);
    check_eq("rstmid_valid", 32'(out_valid), 32'd0);
    repeat (10) @(negedge clk);
    check_eq("rstmid_no_recapture", 32'(lack), 32'd0);
    check_eq("rstmid_still_empty", 32'(out_valid), 32'd0);
    drive_slot();
    lreq = 1'b0;
    repeat (6) @(negedge clk);
    ready_cmd = 1'b1;
    pops_before = pops;
    send(10'h03A);
    drain("rstmid_drain");
    repeat (4) @(negedge clk);
    check_eq("rstmid_one_token", 32'(pops - pops_before), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
